// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 display chain: register addresses,
// frame width, the receiver's register-file layout and the image helper.
package max7219_pkg;

    localparam int FRAME_W = 16;

    localparam logic [3:0] ADDR_NOOP       = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1     = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2     = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3     = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4     = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5     = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6     = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
    localparam logic [3:0] ADDR_DECODE     = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
    localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
    localparam logic [3:0] ADDR_TEST       = 4'hF;

    // Receiver register file; digits[i] holds the row written to address i+1.
    typedef struct packed {
        logic [7:0][7:0] digits;
        logic [7:0]      decode_mode;
        logic [3:0]      intensity;
        logic [2:0]      scan_limit;
        logic            shutdown_n;
        logic            display_test;
    } regs_t;

    // Visible image: test mode lights everything, shutdown blanks everything,
    // otherwise only digits up to the scan limit are shown (no Code-B decode).
    function automatic logic [63:0] compute_disp(regs_t r);
        logic [63:0] img;
        img = '0;
        if (r.display_test) begin
            img = '1;
        end else if (r.shutdown_n) begin
            for (int i = 0; i < 8; i++) begin
                if (3'(i) <= r.scan_limit) img[8*i +: 8] = r.digits[i];
            end
        end
        return img;
    endfunction

endpackage

// File: rtl/max7219_receiver_if.sv
// Serial link of a MAX7219: the display driver is the master, the
// receiver model is the slave that also drives the daisy-chain output.
interface max7219_receiver_if;
    logic sck;
    logic mosi;
    logic cs;
    logic dout;

    modport master (output sck, output mosi, output cs, input dout);
    modport slave  (input sck, input mosi, input cs, output dout);
endinterface

// File: rtl/max7219_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, with single-cycle
// rise/fall pulses taken between the last stage and one more delayed copy.
module max7219_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;

    // Shift the input through the synchroniser chain and keep one extra copy.
    // NOTE: non-blocking assignments make every stage take the previous stage's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_dly  <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_dly  <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  =  r_sync[STAGES-1] & ~r_dly;
    assign o_fall  = ~r_sync[STAGES-1] &  r_dly;

endmodule

// File: rtl/max7219_receiver.sv
// MAX7219 responder: decodes 16-bit SPI frames into the register file,
// exports the raw rows, control registers and the effective 8x8 image.
module max7219_receiver
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    max7219_receiver_if.slave        spi,
    output logic [63:0]              pixels,
    output logic [63:0]              disp,
    output logic [7:0]               decode_mode,
    output logic [3:0]               intensity,
    output logic [2:0]               scan_limit,
    output logic                     shutdown_n,
    output logic                     display_test,
    output logic                     wr_valid,
    output logic [3:0]               wr_addr,
    output logic [7:0]               wr_data,
    output logic                     frame_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

    localparam logic [5:0] CNT_MAX = 6'd63;

    state_t               r_state, w_state_nxt;
    logic [FRAME_W-1:0]   r_sr;
    logic [5:0]           r_cnt;
    logic                 r_dout;
    regs_t                r_regs, w_regs_nxt;
    logic [63:0]          r_disp;
    logic                 r_wr_valid, r_frame_err;
    logic [3:0]           r_wr_addr;
    logic [7:0]           r_wr_data;

    logic w_sck_s, w_sck_rise, w_sck_fall;
    logic w_mosi_s, w_mosi_rise, w_mosi_fall;
    logic w_cs_s, w_cs_rise, w_cs_fall;
    logic w_clear, w_shift, w_dout_upd, w_latch;
    logic w_short, w_bad, w_write;
    logic [3:0] w_addr;
    logic [7:0] w_data;
    logic [2:0] w_digit_idx;
    logic w_unused_sync;

    max7219_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .i_d(spi.sck),
        .o_level(w_sck_s), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
    max7219_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_d(spi.mosi),
        .o_level(w_mosi_s), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));
    max7219_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .i_d(spi.cs),
        .o_level(w_cs_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

    // Only the sck edges and the mosi level matter downstream.
    assign w_unused_sync = &{1'b0, w_sck_s, w_mosi_rise, w_mosi_fall};

    // Frame decode of the finished shift register.
    assign w_addr      = r_sr[11:8];
    assign w_data      = r_sr[7:0];
    assign w_digit_idx = 3'(w_addr - ADDR_DIGIT0);
    assign w_short     = (r_cnt < 6'(FRAME_W));
    assign w_bad       = w_short || (r_cnt[3:0] != 4'd0);
    assign w_write     = w_latch && !w_short;

    // State register of the shift/count FSM.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and per-cycle actions; a cs edge suppresses any sck edge in the same cycle.
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift     = 1'b0;
        w_dout_upd  = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_clear     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_LATCH;
                    w_latch     = 1'b1;
                end else if (!w_cs_s) begin
                    w_shift    = w_sck_rise;
                    w_dout_upd = w_sck_fall;
                end
            end
            ST_LATCH: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_clear     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shift register, saturating bit counter and daisy-chain output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_dout <= 1'b0;
        end else begin
            if (w_clear) begin
                r_cnt <= '0;
            end else if (w_shift) begin
                r_sr <= {r_sr[FRAME_W-2:0], w_mosi_s};
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 6'd1;
            end
            if (w_dout_upd) r_dout <= r_sr[FRAME_W-1];
        end
    end

    // Register-file update for a completed frame; no-op and unused addresses change nothing.
    always_comb begin
        w_regs_nxt = r_regs;
        if (w_write) begin
            case (w_addr)
                ADDR_DECODE:     w_regs_nxt.decode_mode  = w_data;
                ADDR_INTENSITY:  w_regs_nxt.intensity    = w_data[3:0];
                ADDR_SCAN_LIMIT: w_regs_nxt.scan_limit   = w_data[2:0];
                ADDR_SHUTDOWN:   w_regs_nxt.shutdown_n   = w_data[0];
                ADDR_TEST:       w_regs_nxt.display_test = w_data[0];
                default: begin
                    if (w_addr >= ADDR_DIGIT0 && w_addr <= ADDR_DIGIT7)
                        w_regs_nxt.digits[w_digit_idx] = w_data;
                end
            endcase
        end
    end

    // Register file, image and write/error strobes all update on the latch edge.
    // NOTE: the register file is reset explicitly because its contents are outputs that must read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs      <= '0;
            r_disp      <= '0;
            r_wr_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_regs      <= w_regs_nxt;
            r_disp      <= compute_disp(w_regs_nxt);
            r_wr_valid  <= w_write;
            r_frame_err <= w_latch && w_bad;
            if (w_write) begin
                r_wr_addr <= w_addr;
                r_wr_data <= w_data;
            end
        end
    end

    assign spi.dout     = r_dout;
    assign pixels       = r_regs.digits;
    assign disp         = r_disp;
    assign decode_mode  = r_regs.decode_mode;
    assign intensity    = r_regs.intensity;
    assign scan_limit   = r_regs.scan_limit;
    assign shutdown_n   = r_regs.shutdown_n;
    assign display_test = r_regs.display_test;
    assign wr_valid     = r_wr_valid;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign frame_err    = r_frame_err;

endmodule
